issue_stage: RTL and testbench
==============================

// Module: issue_stage
// PURPOSE
//  Pipe-4 issue register feeding the execute stage. Accepts decoded instructions over a valid/ready
//  handshake and resolves operand A/B (regfile, writeback forward, or immediate). Tracks in-flight
//  destinations in pipe 4 and pipe 5, stalls on RAW hazards, squashes on branch/jump flush and
//  counts stall cycles. Execute never back-pressures: pipe 4 advances every cycle (bubble if empty).
// PARAMETERS
//  CTRL_W    32  width of opaque control bundle (fn, alu_fn, mem_op, mulDiv_op, pcselect, imms...) passed to exe
//  CNT_W     32  width of stall performance counter
// PORTS
//  clk          in   1       clock, rising edge
//  nrst         in   1       asynchronous active-low reset
//  dec_valid    in   1       decode presents an instruction
//  dec_ready    out  1       issue accepts it this cycle
//  rs1, rs2     in   5       source register addresses
//  use_rs1/2    in   1       instruction reads rs1 / rs2
//  rd           in   5       destination register
//  we           in   1       instruction writes rd
//  use_imm      in   1       op_b takes imm instead of rs2 value
//  imm          in   32      immediate for op_b
//  ctrl         in   CTRL_W  control bundle, registered unchanged
//  rf_rdata1/2  in   32      regfile read data (combinational on rs1/rs2, written at end of wb cycle)
//  wb_we        in   1       execute writeback enable (we6)
//  wb_rd        in   5       execute writeback address (rd6)
//  wb_data      in   32      execute writeback data (wb_data6)
//  flush        in   1       branch/jump redirect (bjtaken)
//  valid4       out  1       pipe-4 holds a live instruction
//  op_a, op_b   out  32      resolved operands
//  rd4          out  5       destination
//  we4          out  1       write enable, forced 0 when valid4=0
//  ctrl4        out  CTRL_W  registered control bundle
//  stall_cnt    out  CNT_W   saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset: all outputs 0 (valid4, we4, op_a, op_b, rd4, ctrl4, stall_cnt); shadow5 cleared; dec_ready follows comb rule.
//  Shadow5: internal {sv5, srd5} <= {valid4 & we4, rd4} every edge; mirrors exe pipe 5.
//  Hazard on source s (s=rs1 with use_rs1, or rs2 with use_rs2 & !use_imm), s != 0:
//   (valid4 & we4 & rd4==s) | (sv5 & srd5==s)  -> stall.
//  dec_ready = !stall | flush. Accept = dec_valid & dec_ready & !flush.
//  Operand select (priority): s==0 -> 0; wb_we & wb_rd==s & wb_rd!=0 -> wb_data; else rf_rdata.
//   op_b = imm when use_imm, regardless of rs2 value.
//  Pipe-4 update each edge: Accept -> load operands, rd, we, ctrl, valid4=1; otherwise bubble:
//   valid4=0, we4=0, rd4=0, ctrl4=0; op_a/op_b hold (don't-care).
//  Latency: accepted in cycle c -> on outputs c+1; dependent may accept earliest at c+3
//   (forwarded from wb at c+3; from regfile at c+4 and later).
//  Flush: the cycle flush=1 the presented instruction is dropped (dec_ready=1 so decode drains);
//   current pipe-4 contents are not killed (already leaving); shadow5 unaffected.
//  Flush and stall same cycle: flush wins, no stall count.
//  stall_cnt: +1 each cycle dec_valid & stall & !flush; saturates at all-ones, never wraps.
//  rd=0 with we=1: propagated but never creates a hazard.
//  Reset asserted mid-stall: pipe 4 and shadow5 clear immediately; first post-reset instruction has no hazard.
// TESTING
//  T1 back-to-back dependent: I0 addi x5 accepted c0, I1 reads x5 -> dec_ready=0 c1,c2; accept c3, op_a=wb_data.
//  T2 independent stream: 8 instrs no overlap -> dec_ready=1 every cycle, valid4=1 c1..c8, stall_cnt=0.
//  T3 x0 source: rs1=0 while rd4=0 & we4=1 -> no stall, op_a=0 even if rf_rdata1=0xDEADBEEF.
//  T4 flush during stall: stall active, flush=1 -> dec_ready=1, next valid4=0, stall_cnt unchanged.
//  T5 use_imm: rs2 field matches rd4 but use_imm=1 -> no stall, op_b=imm=0x0000_0800.
//  T6 saturation (CNT_W=4): 20 stall cycles -> stall_cnt=0xF; async reset mid-stall -> all outputs 0.

Source files
------------

// File: rtl/issue_stage.sv
// Pipe-4 issue register. Accepts decoded instructions over valid/ready,
// resolves operands from regfile / writeback forward / immediate, tracks
// in-flight destinations in pipe 4 and a pipe-5 shadow, stalls on RAW
// hazards, drops the presented instruction on flush and counts stall cycles.
module issue_stage #(
  parameter int CTRL_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic [4:0]        rd,
  input  logic              we,
  input  logic              use_imm,
  input  logic [31:0]       imm,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  output logic              valid4,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  output logic [4:0]        rd4,
  output logic              we4,
  output logic [CTRL_W-1:0] ctrl4,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Pipe-5 shadow: what execute holds one cycle after leaving pipe 4.
  logic       sv5;
  logic [4:0] srd5;

  logic          haz1;
  logic          haz2;
  logic          stall;
  logic          accept;
  logic [31:0]   opa_nxt;
  logic [31:0]   opb_nxt;

  // Source s collides with a writer still in flight (x0 never collides).
  function automatic logic in_flight(input logic [4:0] s,
                                     input logic v4, input logic [4:0] r4,
                                     input logic v5, input logic [4:0] r5);
    return (s != 5'd0) && ((v4 && (r4 == s)) || (v5 && (r5 == s)));
  endfunction

  // Operand source priority: x0, then writeback forward, then regfile.
  function automatic logic [31:0] sel_op(input logic [4:0] s,
                                         input logic wwe, input logic [4:0] wrd,
                                         input logic [31:0] wdat,
                                         input logic [31:0] rf);
    if (s == 5'd0)
      return 32'd0;
    else if (wwe && (wrd == s))
      return wdat;
    else
      return rf;
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Hazard detection, handshake and operand resolution.
  always_comb begin
    haz1    = use_rs1 && in_flight(rs1, valid4 && we4, rd4, sv5, srd5);
    haz2    = use_rs2 && !use_imm && in_flight(rs2, valid4 && we4, rd4, sv5, srd5);
    stall   = haz1 || haz2;
    dec_ready = !stall || flush;
    accept  = dec_valid && dec_ready && !flush;
    opa_nxt = sel_op(rs1, wb_we, wb_rd, wb_data, rf_rdata1);
    opb_nxt = use_imm ? imm : sel_op(rs2, wb_we, wb_rd, wb_data, rf_rdata2);
  end

  // Pipe-4 register and pipe-5 shadow; empty pipe 4 becomes a bubble.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid4 <= 1'b0;
      we4    <= 1'b0;
      rd4    <= 5'd0;
      ctrl4  <= '0;
      op_a   <= 32'd0;
      op_b   <= 32'd0;
      sv5    <= 1'b0;
      srd5   <= 5'd0;
    end else begin
      sv5  <= valid4 && we4;
      srd5 <= rd4;
      if (accept) begin
        valid4 <= 1'b1;
        we4    <= we;
        rd4    <= rd;
        ctrl4  <= ctrl;
        op_a   <= opa_nxt;
        op_b   <= opb_nxt;
      end else begin
        valid4 <= 1'b0;
        we4    <= 1'b0;
        rd4    <= 5'd0;
        ctrl4  <= '0;
      end
    end
  end

  // Stall performance counter: counts cycles a real instruction waits on a hazard.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      stall_cnt <= '0;
    else if (dec_valid && stall && !flush)
      stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: tb/tb_issue_stage.sv
// Scoreboard bench for issue_stage: the driver pushes the expected pipe-4
// contents of every instruction it expects to be accepted; a negedge monitor
// pops and compares whenever valid4 is high.
module tb_issue_stage;

  localparam int CTRL_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              nrst;
  logic              dec_valid;
  logic              dec_ready;
  logic [4:0]        rs1, rs2, rd, wb_rd, rd4;
  logic              use_rs1, use_rs2, we, use_imm, wb_we, flush, valid4, we4;
  logic [31:0]       imm, rf_rdata1, rf_rdata2, wb_data, op_a, op_b;
  logic [CTRL_W-1:0] ctrl, ctrl4;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic        w;
    logic [31:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  issue_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd(rd), .we(we), .use_imm(use_imm), .imm(imm), .ctrl(ctrl),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .valid4(valid4), .op_a(op_a), .op_b(op_b), .rd4(rd4), .we4(we4),
    .ctrl4(ctrl4), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] d, input logic w,
                         input logic ui, input logic [31:0] im,
                         input logic [31:0] c,
                         input logic [31:0] d1, input logic [31:0] d2);
    dec_valid = v;  rs1 = r1; use_rs1 = u1; rs2 = r2; use_rs2 = u2;
    rd = d; we = w; use_imm = ui; imm = im; ctrl = c;
    rf_rdata1 = d1; rf_rdata2 = d2;
  endtask

  task automatic idle();
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0;
  endtask

  task automatic expect_out(input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] d, input logic w, input logic [31:0] c);
    exp_t e;
    e.a = a; e.b = b; e.d = d; e.w = w; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic chk_rdy(input string nm, input logic req);
    #1;
    chk(nm, {63'd0, dec_ready}, {63'd0, req});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid4"}, {63'd0, valid4}, 64'd0);
    chk({tag, "_we4"}, {63'd0, we4}, 64'd0);
    chk({tag, "_rd4"}, {59'd0, rd4}, 64'd0);
    chk({tag, "_op_a"}, {32'd0, op_a}, 64'd0);
    chk({tag, "_op_b"}, {32'd0, op_b}, 64'd0);
    chk({tag, "_ctrl4"}, {32'd0, ctrl4}, 64'd0);
    chk({tag, "_stall_cnt"}, {60'd0, stall_cnt}, 64'd0);
  endtask

  // Monitor: every live pipe-4 slot must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (valid4 === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid4", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("op_a", {32'd0, op_a}, {32'd0, e.a});
          chk("op_b", {32'd0, op_b}, {32'd0, e.b});
          chk("rd4", {59'd0, rd4}, {59'd0, e.d});
          chk("we4", {63'd0, we4}, {63'd0, e.w});
          chk("ctrl4", {32'd0, ctrl4}, {32'd0, e.c});
        end
      end else begin
        chk("we4_bubble", {63'd0, we4}, 64'd0);
      end
    end
  end

  initial begin
    nrst = 1'b0;
    idle();
    #12;
    chk_zero_outputs("reset");
    chk_rdy("reset_dec_ready", 1'b1);
    tick();
    nrst = 1'b1;
    tick();

    // T1: producer x5, dependent consumer stalls two cycles, then forwards.
    present(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 32'd5, 32'hA0, 32'd100, 32'd0);
    chk_rdy("t1_i0_ready", 1'b1);
    expect_out(32'd100, 32'd5, 5'd5, 1'b1, 32'hA0);
    tick();
    present(1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 32'd0, 32'hA1, 32'd0, 32'd7);
    chk_rdy("t1_stall_c1", 1'b0);
    tick();
    chk_rdy("t1_stall_c2", 1'b0);
    tick();
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    chk_rdy("t1_accept_c3", 1'b1);
    expect_out(32'h1234, 32'd7, 5'd7, 1'b1, 32'hA1);
    tick();
    idle();
    chk("t1_stall_cnt", {60'd0, stall_cnt}, 64'd2);
    tick();

    // T2: independent stream of eight, never stalls.
    for (int i = 0; i < 8; i++) begin
      present(1, 5'd1, 1, 5'd2, 1, 5'(20 + i), 1, 0, 32'd0, 32'hB0 + 32'(i),
              32'(i * 3), 32'(i + 100));
      chk_rdy("t2_ready", 1'b1);
      expect_out(32'(i * 3), 32'(i + 100), 5'(20 + i), 1'b1, 32'hB0 + 32'(i));
      tick();
    end
    idle();
    chk("t2_stall_cnt", {60'd0, stall_cnt}, 64'd2);
    tick();
    tick();

    // T3: rd=0 writer is harmless; x0 sources read as zero, wb to x0 ignored.
    present(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 32'h22, 32'hC0, 32'd11, 32'd0);
    expect_out(32'd11, 32'h22, 5'd0, 1'b1, 32'hC0);
    tick();
    present(1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 32'd0, 32'hC1, 32'hDEADBEEF, 32'hDEADBEEF);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    chk_rdy("t3_x0_ready", 1'b1);
    expect_out(32'd0, 32'd0, 5'd8, 1'b1, 32'hC1);
    tick();
    idle();
    tick();
    tick();

    // T4: flush while stalled drops the instruction and is not counted.
    present(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1, 32'd0, 32'hD0, 32'd1, 32'd0);
    expect_out(32'd1, 32'd0, 5'd9, 1'b1, 32'hD0);
    tick();
    present(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 1, 32'd3, 32'hD1, 32'd2, 32'd0);
    chk_rdy("t4_stall", 1'b0);
    tick();
    flush = 1'b1;
    chk_rdy("t4_flush_ready", 1'b1);
    tick();
    idle();
    chk("t4_valid4_after_flush", {63'd0, valid4}, 64'd0);
    chk("t4_stall_cnt", {60'd0, stall_cnt}, 64'd3);
    tick();
    tick();

    // T5: rs2 matches rd4 but immediate is used, so no stall.
    present(1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1, 32'd0, 32'hE0, 32'd4, 32'd0);
    expect_out(32'd4, 32'd0, 5'd12, 1'b1, 32'hE0);
    tick();
    present(1, 5'd3, 1, 5'd12, 1, 5'd13, 1, 1, 32'h0000_0800, 32'hE1, 32'h33, 32'hFFFF);
    chk_rdy("t5_imm_ready", 1'b1);
    expect_out(32'h33, 32'h800, 5'd13, 1'b1, 32'hE1);
    tick();
    idle();
    tick();
    tick();

    // T6: dependency chain of ten links, two stall cycles each -> saturates.
    present(1, 5'd1, 1, 5'd0, 0, 5'd14, 1, 1, 32'd0, 32'hF0, 32'd9, 32'd0);
    expect_out(32'd9, 32'd0, 5'd14, 1'b1, 32'hF0);
    tick();
    for (int k = 0; k < 10; k++) begin
      present(1, 5'(14 + k), 1, 5'd0, 0, 5'(15 + k), 1, 1, 32'(k), 32'h100 + 32'(k),
              32'(k * 5 + 1), 32'd0);
      chk_rdy("t6_stall_a", 1'b0);
      tick();
      chk_rdy("t6_stall_b", 1'b0);
      tick();
      chk_rdy("t6_accept", 1'b1);
      chk("t6_stall_cnt", {60'd0, stall_cnt},
          (3 + 2 * (k + 1) > 15) ? 64'd15 : 64'(3 + 2 * (k + 1)));
      expect_out(32'(k * 5 + 1), 32'(k), 5'(15 + k), 1'b1, 32'h100 + 32'(k));
      tick();
    end
    idle();
    tick();
    tick();

    // Async reset mid-stall: producer is live in pipe 4 when reset hits.
    present(1, 5'd1, 1, 5'd0, 0, 5'd30, 1, 1, 32'd0, 32'h200, 32'd6, 32'd0);
    tick();
    present(1, 5'd30, 1, 5'd0, 0, 5'd31, 1, 1, 32'd0, 32'h201, 32'h77, 32'd0);
    chk_rdy("rst_pre_stall", 1'b0);
    chk("rst_pre_valid4", {63'd0, valid4}, 64'd1);
    nrst = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    chk_rdy("midrst_dec_ready", 1'b1);
    nrst = 1'b1;
    chk_rdy("post_rst_ready", 1'b1);
    expect_out(32'h77, 32'd0, 5'd31, 1'b1, 32'h201);
    tick();
    idle();
    tick();
    tick();
    tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
